// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch PC controller: holds the PC and chooses the next PC from sequential,
// jump, branch, interrupt and exception sources. It also drives the IF/ID and ID/EX squash controls.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Hold,
  input  logic        ID_JumpEn,
  input  logic [31:0] ID_JumpTarget,
  input  logic        ID_Exc,
  input  logic [31:0] ID_PC_4,
  input  logic        EX_BranchEn,
  input  logic [31:0] EX_BranchTarget,
  input  logic        IRQ,
  input  logic [31:0] IMem_Data,
  output logic [31:0] IMem_Addr,
  output logic [31:0] IF_PC_4,
  output logic [31:0] IF_Instruct,
  output logic        IF_NoIRQ,
  output logic [1:0]  IF_ID_Src,
  output logic        ID_EX_Flush,
  output logic [31:0] EPC
);

  localparam logic [1:0] SRC_PASS   = 2'd0;
  localparam logic [1:0] SRC_BUBBLE = 2'd1;
  localparam logic [1:0] SRC_HOLD   = 2'd2;

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        irq_pend_q, irq_pend_d;
  logic [1:0]  shadow_q, shadow_d;
  logic [31:0] pc_seq;
  logic        take;
  logic [1:0]  src;
  logic        flush;

  assign pc_seq = {pc_q[31], pc_q[30:0] + 31'd4};

  always_comb begin
    pc_d     = pc_seq;
    epc_d    = epc_q;
    src      = SRC_PASS;
    flush    = 1'b0;
    take     = 1'b0;
    shadow_d = (shadow_q == 2'd0) ? 2'd0 : shadow_q - 2'd1;
    // Redirect targets may only keep the kernel bit when already in kernel mode.
    if (ID_Exc) begin
      pc_d     = {1'b1, EXC_VEC[30:0]};
      epc_d    = ID_PC_4;
      src      = SRC_BUBBLE;
      flush    = 1'b1;
      shadow_d = 2'd2;
    end else if (EX_BranchEn) begin
      pc_d     = {EX_BranchTarget[31] & pc_q[31], EX_BranchTarget[30:0]};
      src      = SRC_BUBBLE;
      flush    = 1'b1;
      shadow_d = 2'd2;
    end else if (Hold) begin
      pc_d  = pc_q;
      src   = SRC_HOLD;
      flush = 1'b1;
    end else if (ID_JumpEn) begin
      pc_d     = {ID_JumpTarget[31] & pc_q[31], ID_JumpTarget[30:0]};
      src      = SRC_BUBBLE;
      shadow_d = 2'd2;
    end else if (irq_pend_q && !pc_q[31] && shadow_q == 2'd0) begin
      take     = 1'b1;
      pc_d     = {1'b1, IRQ_VEC[30:0]};
      epc_d    = pc_q;
      src      = SRC_BUBBLE;
      shadow_d = 2'd2;
    end
    irq_pend_d = (irq_pend_q | IRQ) & ~take;
    if (reset) begin
      src   = SRC_BUBBLE;
      flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      irq_pend_q <= 1'b0;
      shadow_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      irq_pend_q <= irq_pend_d;
      shadow_q   <= shadow_d;
    end
  end

  assign IMem_Addr   = pc_q;
  assign IF_PC_4     = pc_seq;
  assign IF_Instruct = IMem_Data;
  assign IF_NoIRQ    = pc_q[31];
  assign IF_ID_Src   = src;
  assign ID_EX_Flush = flush;
  assign EPC         = epc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed steps queue hand-computed expectations,
// and a negedge monitor pops and compares them in the cycle they fall due.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, Hold, ID_JumpEn, ID_Exc, EX_BranchEn, IRQ;
  logic [31:0] ID_JumpTarget, ID_PC_4, EX_BranchTarget, IMem_Data;
  logic [31:0] IMem_Addr, IF_PC_4, IF_Instruct, EPC;
  logic        IF_NoIRQ, ID_EX_Flush;
  logic [1:0]  IF_ID_Src;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .RESET_PC(32'h8000_0000),
    .IRQ_VEC (32'h8000_0004),
    .EXC_VEC (32'h8000_0008)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .Hold           (Hold),
    .ID_JumpEn      (ID_JumpEn),
    .ID_JumpTarget  (ID_JumpTarget),
    .ID_Exc         (ID_Exc),
    .ID_PC_4        (ID_PC_4),
    .EX_BranchEn    (EX_BranchEn),
    .EX_BranchTarget(EX_BranchTarget),
    .IRQ            (IRQ),
    .IMem_Data      (IMem_Data),
    .IMem_Addr      (IMem_Addr),
    .IF_PC_4        (IF_PC_4),
    .IF_Instruct    (IF_Instruct),
    .IF_NoIRQ       (IF_NoIRQ),
    .IF_ID_Src      (IF_ID_Src),
    .ID_EX_Flush    (ID_EX_Flush),
    .EPC            (EPC)
  );

  // Instruction ROM model: contents are the inverted address.
  assign IMem_Data = ~IMem_Addr;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  src;
    logic        flush;
    logic [2:0]  m;   // [0] src/flush, [1] pc, [2] epc
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc != cyc) begin
        chk({e.name, "_cycle"}, cyc, e.cyc);
      end else begin
        if (e.m[0]) begin
          chk({e.name, "_src"}, {30'd0, IF_ID_Src}, {30'd0, e.src});
          chk({e.name, "_flush"}, {31'd0, ID_EX_Flush}, {31'd0, e.flush});
        end
        if (e.m[1]) begin
          chk({e.name, "_pc"}, IMem_Addr, e.pc);
          chk({e.name, "_pc4"}, IF_PC_4, {e.pc[31], e.pc[30:0] + 31'd4});
          chk({e.name, "_noirq"}, {31'd0, IF_NoIRQ}, {31'd0, e.pc[31]});
          chk({e.name, "_instr"}, IF_Instruct, ~e.pc);
        end
        if (e.m[2]) chk({e.name, "_epc"}, EPC, e.epc);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic hold,
                      input logic jen, input logic [31:0] jt,
                      input logic ben, input logic [31:0] bt,
                      input logic exc, input logic [31:0] ip4, input logic irq,
                      input logic [1:0] s, input logic f,
                      input logic [31:0] pcn, input logic [31:0] epcn);
    exp_t e;
    reset = rst; Hold = hold; ID_JumpEn = jen; ID_JumpTarget = jt;
    EX_BranchEn = ben; EX_BranchTarget = bt; ID_Exc = exc; ID_PC_4 = ip4; IRQ = irq;
    e.cyc = cyc; e.name = nm; e.pc = '0; e.epc = '0; e.src = s; e.flush = f; e.m = 3'b001;
    q.push_back(e);
    e.cyc = cyc + 1; e.pc = pcn; e.epc = epcn; e.m = 3'b110;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Hold = 1'b0; ID_JumpEn = 1'b0; ID_Exc = 1'b0; EX_BranchEn = 1'b0; IRQ = 1'b0;
    ID_JumpTarget = '0; ID_PC_4 = '0; EX_BranchTarget = '0;
    @(posedge clk);
    #1;
    //    name         rst hold jen jt            ben bt            exc ip4    irq src fl next_pc       next_epc
    step("rst_a",      1, 1, 1, 32'h0000_1234, 0, 32'h0,         0, 32'h0,  1, 1, 1, 32'h8000_0000, 32'h0);
    step("rst_b",      1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 1, 1, 32'h8000_0000, 32'h0);
    step("release",    0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h8000_0004, 32'h0);
    step("to_user",    0, 0, 1, 32'h0000_0010, 0, 32'h0,         0, 32'h0,  0, 1, 0, 32'h0000_0010, 32'h0);
    step("jmp_user",   0, 0, 1, 32'h8000_0040, 0, 32'h0,         0, 32'h0,  0, 1, 0, 32'h0000_0040, 32'h0);
    step("br_vs_jmp",  0, 0, 1, 32'h0000_0200, 1, 32'h0000_0100, 0, 32'h0,  0, 1, 1, 32'h0000_0100, 32'h0);
    step("hold_j1",    0, 1, 1, 32'h0000_0300, 0, 32'h0,         0, 32'h0,  0, 2, 1, 32'h0000_0100, 32'h0);
    step("hold_j2",    0, 1, 1, 32'h0000_0300, 0, 32'h0,         0, 32'h0,  0, 2, 1, 32'h0000_0100, 32'h0);
    step("hold_drop",  0, 0, 1, 32'h0000_0300, 0, 32'h0,         0, 32'h0,  0, 1, 0, 32'h0000_0300, 32'h0);
    step("seq",        0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h0000_0304, 32'h0);
    step("j_wrap",     0, 0, 1, 32'h7FFF_FFFC, 0, 32'h0,         0, 32'h0,  0, 1, 0, 32'h7FFF_FFFC, 32'h0);
    step("wrap",       0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h0000_0000, 32'h0);
    step("seq_sh0",    0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h0000_0004, 32'h0);
    step("irq_raise",  0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  1, 0, 0, 32'h0000_0008, 32'h0);
    step("irq_take",   0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  1, 1, 0, 32'h8000_0004, 32'h0000_0008);
    step("kern_ign",   0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  1, 0, 0, 32'h8000_0008, 32'h0000_0008);
    step("kern_ign2",  0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h8000_000C, 32'h0000_0008);
    step("jr_user",    0, 0, 1, 32'h0000_0020, 0, 32'h0,         0, 32'h0,  0, 1, 0, 32'h0000_0020, 32'h0000_0008);
    step("shadow2",    0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h0000_0024, 32'h0000_0008);
    step("shadow1",    0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h0000_0028, 32'h0000_0008);
    step("irq_late",   0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 1, 0, 32'h8000_0004, 32'h0000_0028);
    step("exc_br",     0, 0, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h34, 0, 1, 1, 32'h8000_0008, 32'h0000_0034);
    step("kjump",      0, 0, 1, 32'h8000_0100, 0, 32'h0,         0, 32'h0,  0, 1, 0, 32'h8000_0100, 32'h0000_0034);
    step("kbr_user",   0, 0, 0, 32'h0,         1, 32'h0000_0050, 0, 32'h0,  0, 1, 1, 32'h0000_0050, 32'h0000_0034);
    step("ubr_kern",   0, 0, 0, 32'h0,         1, 32'h8000_0060, 0, 32'h0,  0, 1, 1, 32'h0000_0060, 32'h0000_0034);
    step("irq_pend",   0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  1, 0, 0, 32'h0000_0064, 32'h0000_0034);
    step("rst_mid",    1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 1, 1, 32'h8000_0000, 32'h0);
    step("post_rst",   0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h8000_0004, 32'h0);
    step("user_again", 0, 0, 1, 32'h0000_0040, 0, 32'h0,         0, 32'h0,  0, 1, 0, 32'h0000_0040, 32'h0);
    step("no_pend_a",  0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h0000_0044, 32'h0);
    step("no_pend_b",  0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h0000_0048, 32'h0);
    step("no_pend_c",  0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h0000_004C, 32'h0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
